// File: rtl/instr_encoder_if.sv
// Field-bundle input stream and instruction-memory write port of instr_encoder.
// The encoder takes the slave side; the program source / memory model takes master.
interface instr_encoder_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  in_valid;
  logic                  in_ready;
  logic                  in_last;
  logic [3:0]            in_class;
  logic [2:0]            in_funct3;
  logic                  in_alt;
  logic [4:0]            in_rd;
  logic [4:0]            in_rs1;
  logic [4:0]            in_rs2;
  logic [31:0]           in_imm;
  logic                  wr_en;
  logic                  wr_ready;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [31:0]           wr_data;

  modport slave (
    input  in_valid, in_last, in_class, in_funct3, in_alt,
    input  in_rd, in_rs1, in_rs2, in_imm, wr_ready,
    output in_ready, wr_en, wr_addr, wr_data
  );

  modport master (
    output in_valid, in_last, in_class, in_funct3, in_alt,
    output in_rd, in_rs1, in_rs2, in_imm, wr_ready,
    input  in_ready, wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/instr_encoder.sv
// Streaming RV32I encoder: packs decoded field bundles into instruction words and
// writes them to consecutive instruction-memory addresses from a loaded base.
module instr_encoder #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  instr_encoder_if.slave        bus,
  output logic                  busy,
  output logic                  done,
  output logic [7:0]            err_count
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  localparam logic [3:0] C_R      = 4'd0;
  localparam logic [3:0] C_IALU   = 4'd1;
  localparam logic [3:0] C_LOAD   = 4'd2;
  localparam logic [3:0] C_STORE  = 4'd3;
  localparam logic [3:0] C_BRANCH = 4'd4;
  localparam logic [3:0] C_JAL    = 4'd5;
  localparam logic [3:0] C_JALR   = 4'd6;
  localparam logic [3:0] C_LUI    = 4'd7;
  localparam logic [3:0] C_AUIPC  = 4'd8;
  localparam logic [3:0] C_SYSTEM = 4'd9;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;

  state_e                 state_q, state_d;
  logic                   wr_en_q, wr_en_d;
  logic [ADDR_WIDTH-1:0]  wr_addr_q, wr_addr_d;
  logic [DATA_WIDTH-1:0]  wr_data_q, wr_data_d;
  logic [7:0]             err_q, err_d;
  logic                   done_q, done_d;

  logic                   in_ready;
  logic                   wr_fire;
  logic                   accept;
  logic                   bad;
  logic [31:0]            word;

  function automatic logic fits_i(input logic signed [31:0] imm);
    return (imm >= -32'sd2048) && (imm <= 32'sd2047);
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  function automatic logic is_illegal(input logic [3:0]         cls,
                                      input logic [2:0]         f3,
                                      input logic               alt,
                                      input logic signed [31:0] imm);
    logic ill;
    ill = 1'b0;
    case (cls)
      C_R:      ill = alt && (f3 != 3'b000) && (f3 != 3'b101);
      C_IALU: begin
        // shift forms carry a 5-bit shamt; alt is only meaningful on srai
        if (f3 == 3'b001 || f3 == 3'b101)
          ill = (alt && f3 != 3'b101) || (imm < 32'sd0) || (imm > 32'sd31);
        else
          ill = alt || !fits_i(imm);
      end
      C_LOAD:   ill = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111) || !fits_i(imm);
      C_STORE:  ill = (f3 > 3'b010) || !fits_i(imm);
      C_BRANCH: ill = (f3 == 3'b010) || (f3 == 3'b011) || imm[0] ||
                      (imm < -32'sd4096) || (imm > 32'sd4094);
      C_JAL:    ill = imm[0] || (imm < -32'sd1048576) || (imm > 32'sd1048574);
      C_JALR:   ill = !fits_i(imm);
      C_LUI, C_AUIPC: ill = (imm[11:0] != 12'd0);
      C_SYSTEM: ill = 1'b0;
      default:  ill = 1'b1;
    endcase
    return ill;
  endfunction

  function automatic logic [31:0] encode(input logic [3:0]  cls,
                                         input logic [2:0]  f3,
                                         input logic        alt,
                                         input logic [4:0]  rd,
                                         input logic [4:0]  rs1,
                                         input logic [4:0]  rs2,
                                         input logic [31:0] imm);
    logic [6:0]  f7;
    logic [31:0] w;
    f7 = alt ? 7'h20 : 7'h00;
    case (cls)
      C_R:      w = {f7, rs2, rs1, f3, rd, OP_R};
      C_IALU:   w = (f3 == 3'b001 || f3 == 3'b101) ? {f7, imm[4:0], rs1, f3, rd, OP_IALU}
                                                   : {imm[11:0], rs1, f3, rd, OP_IALU};
      C_LOAD:   w = {imm[11:0], rs1, f3, rd, OP_LOAD};
      C_STORE:  w = {imm[11:5], rs2, rs1, f3, imm[4:0], OP_STORE};
      C_BRANCH: w = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], OP_BRANCH};
      C_JAL:    w = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OP_JAL};
      C_JALR:   w = {imm[11:0], rs1, 3'b000, rd, OP_JALR};
      C_LUI:    w = {imm[31:12], rd, OP_LUI};
      C_AUIPC:  w = {imm[31:12], rd, OP_AUIPC};
      C_SYSTEM: w = alt ? 32'h0010_0073 : 32'h0000_0073;
      default:  w = NOP;
    endcase
    return w;
  endfunction

  // The single output entry may be drained and refilled in the same cycle.
  assign in_ready = (state_q == RUN) && (!wr_en_q || bus.wr_ready);
  assign wr_fire  = wr_en_q && bus.wr_ready;
  assign accept   = bus.in_valid && in_ready;

  assign bad  = is_illegal(bus.in_class, bus.in_funct3, bus.in_alt, bus.in_imm);
  assign word = bad ? NOP : encode(bus.in_class, bus.in_funct3, bus.in_alt,
                                   bus.in_rd, bus.in_rs1, bus.in_rs2, bus.in_imm);

  always_comb begin
    state_d   = state_q;
    wr_en_d   = wr_en_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    err_d     = err_q;
    done_d    = 1'b0;

    // wr_addr always points at the word being (or about to be) written
    if (wr_fire) begin
      wr_en_d   = 1'b0;
      wr_addr_d = wr_addr_q + ADDR_WIDTH'(4);
    end

    if (accept) begin
      wr_en_d   = 1'b1;
      wr_data_d = DATA_WIDTH'(word);
      if (bad) err_d = sat_inc(err_q);
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = RUN;
          wr_addr_d = base_addr;
          err_d     = 8'd0;
        end
      end
      RUN: begin
        if (accept && bus.in_last) state_d = DRAIN;
      end
      DRAIN: begin
        if (wr_fire) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      err_q     <= 8'd0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      err_q     <= err_d;
      done_q    <= done_d;
    end
  end

  assign bus.in_ready = in_ready;
  assign bus.wr_en    = wr_en_q;
  assign bus.wr_addr  = wr_addr_q;
  assign bus.wr_data  = 32'(wr_data_q);
  assign busy         = (state_q != IDLE);
  assign done         = done_q;
  assign err_count    = err_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: table of field bundles with hand-encoded words, a write
// scoreboard, and directed sequences for start/valid overlap, stalls and reset.
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] base_addr = '0;
  logic        busy, done;
  logic [7:0]  err_count;

  instr_encoder_if #(.ADDR_WIDTH(32)) bus ();

  instr_encoder #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .base_addr (base_addr),
    .bus       (bus),
    .busy      (busy),
    .done      (done),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        newp;
    logic [31:0] base;
    logic [3:0]  cls;
    logic [2:0]  f3;
    logic        alt;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] imm;
    logic        last;
    logic [31:0] exp;
    logic        ill;
  } vec_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  vec_t        tbl[$];
  wr_t         sb[$];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          last_wr_cyc = -10;
  int          exp_err = 0;
  logic [31:0] exp_addr = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b", nm, act, exp);
    end
  endtask

  // write monitor / scoreboard
  always @(negedge clk) begin
    if (rst_n && bus.wr_en && bus.wr_ready) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_write: got addr=%h data=%h want no write", bus.wr_addr, bus.wr_data);
      end else begin
        wr_t e;
        e = sb.pop_front();
        chk($sformatf("wr_addr@%h", e.addr), bus.wr_addr, e.addr);
        chk($sformatf("wr_data@%h", e.addr), bus.wr_data, e.data);
      end
      last_wr_cyc = cyc;
    end
  end

  function automatic vec_t mk(input logic newp, input logic [31:0] base, input logic [3:0] cls,
                              input logic [2:0] f3, input logic alt, input logic [4:0] rd,
                              input logic [4:0] rs1, input logic [4:0] rs2, input logic [31:0] imm,
                              input logic last, input logic [31:0] exp, input logic ill);
    vec_t v;
    v.newp = newp; v.base = base; v.cls = cls; v.f3 = f3; v.alt = alt;
    v.rd = rd; v.rs1 = rs1; v.rs2 = rs2; v.imm = imm; v.last = last;
    v.exp = exp; v.ill = ill;
    return v;
  endfunction

  task automatic set_fields(input vec_t v);
    bus.in_class  = v.cls;
    bus.in_funct3 = v.f3;
    bus.in_alt    = v.alt;
    bus.in_rd     = v.rd;
    bus.in_rs1    = v.rs1;
    bus.in_rs2    = v.rs2;
    bus.in_imm    = v.imm;
    bus.in_last   = v.last;
  endtask

  task automatic push_exp(input vec_t v);
    wr_t e;
    e.addr = exp_addr;
    e.data = v.exp;
    sb.push_back(e);
    exp_addr = exp_addr + 32'd4;
    if (v.ill && exp_err < 255) exp_err++;
  endtask

  task automatic do_start(input logic [31:0] b);
    start     = 1'b1;
    base_addr = b;
    @(posedge clk);
    #1;
    start    = 1'b0;
    exp_addr = b;
    exp_err  = 0;
  endtask

  task automatic send(input vec_t v);
    int n;
    n = 0;
    set_fields(v);
    bus.in_valid = 1'b1;
    @(negedge clk);
    while (!bus.in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk1("send_ready", bus.in_ready, 1'b1);
    if (bus.in_ready) push_exp(v);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    int n;
    n = 0;
    @(negedge clk);
    while (!done && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk1({nm, "_done_seen"}, done, 1'b1);
    if (done) begin
      chk({nm, "_done_cycle"}, 32'(cyc), 32'(last_wr_cyc + 1));
      chk1({nm, "_busy_low"}, busy, 1'b0);
      chk({nm, "_sb_empty"}, 32'(sb.size()), 32'd0);
      @(negedge clk);
      chk1({nm, "_done_pulse"}, done, 1'b0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t a, b, c;

    bus.in_valid = 1'b0; bus.in_last = 1'b0; bus.in_class = '0; bus.in_funct3 = '0;
    bus.in_alt = 1'b0; bus.in_rd = '0; bus.in_rs1 = '0; bus.in_rs2 = '0; bus.in_imm = '0;
    bus.wr_ready = 1'b1;

    // program 1: add / sub
    tbl.push_back(mk(1, 32'h100, 0, 3'd0, 0, 5'd3, 5'd1, 5'd2, 32'd0, 0, 32'h002081B3, 0));
    tbl.push_back(mk(0, 0,       0, 3'd0, 1, 5'd3, 5'd1, 5'd2, 32'd0, 1, 32'h402081B3, 0));
    // program 2: addi, srai, sw, lui, beq, jal
    tbl.push_back(mk(1, 32'h200, 1, 3'd0, 0, 5'd5, 5'd0, 5'd0, -32'sd1, 0, 32'hFFF00293, 0));
    tbl.push_back(mk(0, 0,       1, 3'd5, 1, 5'd4, 5'd1, 5'd0, 32'd3, 0, 32'h4030D213, 0));
    tbl.push_back(mk(0, 0,       3, 3'd2, 0, 5'd0, 5'd1, 5'd2, 32'd4, 0, 32'h0020A223, 0));
    tbl.push_back(mk(0, 0,       7, 3'd0, 0, 5'd5, 5'd0, 5'd0, 32'h12345000, 0, 32'h123452B7, 0));
    tbl.push_back(mk(0, 0,       4, 3'd0, 0, 5'd0, 5'd1, 5'd2, 32'd8, 0, 32'h00208463, 0));
    tbl.push_back(mk(0, 0,       5, 3'd0, 0, 5'd1, 5'd0, 5'd0, 32'd16, 1, 32'h010000EF, 0));
    // program 3: lw, jalr (funct3 forced), bne negative, auipc, ecall, ebreak
    tbl.push_back(mk(1, 32'h280, 2, 3'd2, 0, 5'd6, 5'd7, 5'd0, -32'sd4, 0, 32'hFFC3A303, 0));
    tbl.push_back(mk(0, 0,       6, 3'd3, 0, 5'd1, 5'd2, 5'd0, 32'd8, 0, 32'h008100E7, 0));
    tbl.push_back(mk(0, 0,       4, 3'd1, 0, 5'd0, 5'd3, 5'd4, -32'sd8, 0, 32'hFE419CE3, 0));
    tbl.push_back(mk(0, 0,       8, 3'd0, 0, 5'd10, 5'd0, 5'd0, 32'hFFFFF000, 0, 32'hFFFFF517, 0));
    tbl.push_back(mk(0, 0,       9, 3'd0, 0, 5'd0, 5'd0, 5'd0, 32'd0, 0, 32'h00000073, 0));
    tbl.push_back(mk(0, 0,       9, 3'd7, 1, 5'd5, 5'd6, 5'd7, 32'd44, 1, 32'h00100073, 0));
    // program 4: illegal addi imm, odd beq, bad class
    tbl.push_back(mk(1, 32'h400, 1, 3'd0, 0, 5'd1, 5'd1, 5'd0, 32'd2048, 0, 32'h00000013, 1));
    tbl.push_back(mk(0, 0,       4, 3'd0, 0, 5'd0, 5'd1, 5'd2, 32'd3, 0, 32'h00000013, 1));
    tbl.push_back(mk(0, 0,       12, 3'd0, 0, 5'd1, 5'd1, 5'd1, 32'd0, 1, 32'h00000013, 1));
    // program 5: range boundaries, legal then illegal
    tbl.push_back(mk(1, 32'h480, 1, 3'd0, 0, 5'd0, 5'd0, 5'd0, -32'sd2048, 0, 32'h80000013, 0));
    tbl.push_back(mk(0, 0,       5, 3'd0, 0, 5'd0, 5'd0, 5'd0, -32'sd1048576, 0, 32'h8000006F, 0));
    tbl.push_back(mk(0, 0,       5, 3'd0, 0, 5'd1, 5'd0, 5'd0, 32'd1048576, 0, 32'h00000013, 1));
    tbl.push_back(mk(0, 0,       7, 3'd0, 0, 5'd5, 5'd0, 5'd0, 32'h12345001, 0, 32'h00000013, 1));
    tbl.push_back(mk(0, 0,       1, 3'd1, 0, 5'd2, 5'd2, 5'd0, 32'd32, 1, 32'h00000013, 1));
    // program 6: address wrap
    tbl.push_back(mk(1, 32'hFFFFFFFC, 0, 3'd0, 0, 5'd3, 5'd1, 5'd2, 32'd0, 0, 32'h002081B3, 0));
    tbl.push_back(mk(0, 0,       0, 3'd0, 1, 5'd3, 5'd1, 5'd2, 32'd0, 1, 32'h402081B3, 0));

    // reset state
    repeat (3) @(negedge clk);
    chk1("rst_in_ready", bus.in_ready, 1'b0);
    chk1("rst_wr_en", bus.wr_en, 1'b0);
    chk("rst_wr_addr", bus.wr_addr, 32'h0);
    chk("rst_wr_data", bus.wr_data, 32'h0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_done", done, 1'b0);
    chk("rst_err", 32'(err_count), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].newp) do_start(tbl[i].base);
      send(tbl[i]);
      if (tbl[i].last) begin
        wait_done($sformatf("prog_end%0d", i));
        chk($sformatf("err_count%0d", i), 32'(err_count), 32'(exp_err));
        @(posedge clk);
        #1;
      end
    end

    // start with a last bundle already valid: it must not be taken that cycle
    a = tbl[0];
    a.last = 1'b1;
    set_fields(a);
    bus.in_valid = 1'b1;
    start = 1'b1;
    base_addr = 32'h700;
    #1;
    chk1("start_cycle_in_ready", bus.in_ready, 1'b0);
    @(posedge clk);
    #1;
    start = 1'b0;
    bus.in_valid = 1'b0;
    exp_addr = 32'h700;
    exp_err = 0;
    @(negedge clk);
    chk1("start_busy", busy, 1'b1);
    chk1("start_no_wr", bus.wr_en, 1'b0);
    @(posedge clk);
    #1;
    send(a);
    wait_done("start_overlap");
    @(posedge clk);
    #1;

    // back-pressure: hold wr_ready low three cycles with a bundle waiting
    a = tbl[2]; b = tbl[3]; c = tbl[4];
    c.last = 1'b1;
    bus.wr_ready = 1'b0;
    do_start(32'h300);
    send(a);
    set_fields(b);
    bus.in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk1($sformatf("stall_in_ready%0d", k), bus.in_ready, 1'b0);
      chk1($sformatf("stall_wr_en%0d", k), bus.wr_en, 1'b1);
      chk($sformatf("stall_wr_addr%0d", k), bus.wr_addr, 32'h300);
      chk($sformatf("stall_wr_data%0d", k), bus.wr_data, a.exp);
    end
    bus.wr_ready = 1'b1;
    #1;
    chk1("unstall_in_ready", bus.in_ready, 1'b1);
    push_exp(b);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    send(c);
    wait_done("stall");
    @(posedge clk);
    #1;

    // asynchronous reset with a stalled write pending
    bus.wr_ready = 1'b0;
    do_start(32'h500);
    send(tbl[16]);
    @(negedge clk);
    chk1("pre_rst_wr_en", bus.wr_en, 1'b1);
    chk("pre_rst_err", 32'(err_count), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk1("async_rst_wr_en", bus.wr_en, 1'b0);
    chk1("async_rst_busy", busy, 1'b0);
    chk("async_rst_err", 32'(err_count), 32'd0);
    chk1("async_rst_in_ready", bus.in_ready, 1'b0);
    sb.delete();
    bus.wr_ready = 1'b1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    do_start(32'h600);
    send(tbl[1]);
    wait_done("after_reset");
    chk("after_reset_err", 32'(err_count), 32'd0);

    repeat (2) @(negedge clk);
    chk("final_sb_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
